// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB initiator bridge and its neighbours.
//   - apb_state_e  : bridge FSM states (IDLE -> SETUP -> ACCESS)
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - PERIPH_BASE / PERIPH_LIMIT : peripheral window, shared with the
//     downstream address decoder (the bridge itself does not qualify addresses)
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [31:0] PERIPH_BASE  = 32'h0000_0200;
  localparam logic [31:0] PERIPH_LIMIT = 32'h0000_11FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Decoder-side helper: true when a byte address falls in the peripheral window.
  function automatic logic in_periph_window(input logic [31:0] addr);
    return (addr >= PERIPH_BASE) && (addr <= PERIPH_LIMIT);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
//   Wait-state counter for the APB ACCESS phase. Cleared at SETUP, advanced on
//   every ACCESS cycle where the slave stalls, saturates at TIMEOUT.
// Ports:
//   clk      in  : clock
//   rst_n    in  : synchronous active-low reset
//   clear    in  : zero the counter (has priority over enable)
//   enable   in  : count one wait state
//   expired  out : counter has reached TIMEOUT
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned       CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == LIMIT);

  always_comb begin
    // NOTE: default first so every path assigns count_d; no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      // Saturating: once at LIMIT the count holds rather than wrapping.
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and state updates
  // use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Converts single-beat load/store requests from the core's data port into
//   APB3 transfers (IDLE -> SETUP -> ACCESS) and returns a one-cycle response.
//   A wait-state timeout forces an error completion if the slave never answers.
// Ports:
//   PCLK, PRESETn          : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata  : core request (held by the core until cpu_ready)
//   cpu_ready              : bridge is IDLE and can accept this cycle
//   cpu_rvalid             : one-cycle completion pulse
//   cpu_rdata / cpu_err    : response, valid with cpu_rvalid
//   PSEL/PENABLE/PWRITE    : APB control toward decoder and slaves
//   PADDR / PWDATA         : APB address and write data (held from accept)
//   PRDATA/PREADY/PSLVERR  : APB slave response
// -----------------------------------------------------------------------------
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q,  state_d;
  logic [ADDR_W-1:0] paddr_q,  paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          paddr_d  = cpu_addr;
          pwrite_d = cpu_we;
          // Reads drive zero on PWDATA so stale write data never leaks out.
          pwdata_d = cpu_we ? cpu_wdata : '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        timer_clear = 1'b1;
        state_d     = ACCESS;
      end

      ACCESS: begin
        // A ready slave wins even on the cycle the timer expires.
        if (PREADY) begin
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : PRDATA;
          err_d    = PSLVERR;
          state_d  = IDLE;
        end else if (timer_expired) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Ready is withheld while reset is asserted so all outputs read zero then.
  assign cpu_ready  = (state_q == IDLE) && PRESETn;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;

  assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge (TIMEOUT = 4). Each transfer is
//   described by a txn_t; expected APB phase lengths and responses are derived
//   from the transfer's slave wait count by the exp_* functions below.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int unsigned TIMEOUT = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  waits;   // PREADY=0 cycles before the slave answers
    logic [31:0] prdata;
    logic        slverr;
  } txn_t;

  logic        PCLK;
  logic        PRESETn;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int tests;
  int fails;

  apb_master_bridge #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- reference model ----------------
  function automatic bit is_timeout(input txn_t t);
    return int'(t.waits) > int'(TIMEOUT);
  endfunction

  // ACCESS lasts waits+1 cycles, capped at TIMEOUT+1.
  function automatic int exp_access(input txn_t t);
    return is_timeout(t) ? int'(TIMEOUT) + 1 : int'(t.waits) + 1;
  endfunction

  function automatic logic [31:0] exp_rdata(input txn_t t);
    if (is_timeout(t) || t.we) return 32'h0;
    return t.prdata;
  endfunction

  function automatic logic exp_err(input txn_t t);
    return is_timeout(t) ? 1'b1 : t.slverr;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int waits,
                              input logic [31:0] prdata, input logic slverr);
    txn_t t;
    t.we     = we;
    t.addr   = addr;
    t.wdata  = wdata;
    t.waits  = 8'(waits);
    t.prdata = prdata;
    t.slverr = slverr;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
              int'($urandom_range(0, 6)), $urandom, 1'($urandom));
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_apb(input string ph, input txn_t t, input logic en);
    check({ph, ".psel"},    32'(PSEL),    32'h1);
    check({ph, ".penable"}, 32'(PENABLE), 32'(en));
    check({ph, ".paddr"},   PADDR,        t.addr);
    check({ph, ".pwrite"},  32'(PWRITE),  32'(t.we));
    check({ph, ".pwdata"},  PWDATA,       t.we ? t.wdata : 32'h0);
    check({ph, ".ready"},   32'(cpu_ready),  32'h0);
    check({ph, ".rvalid"},  32'(cpu_rvalid), 32'h0);
  endtask

  // Present a request at the current negedge; bridge must be ready.
  task automatic issue(input txn_t t);
    check("issue.ready", 32'(cpu_ready), 32'h1);
    cpu_req   = 1'b1;
    cpu_we    = t.we;
    cpu_addr  = t.addr;
    cpu_wdata = t.wdata;
  endtask

  // Run one transfer from its accept edge to the cpu_rvalid cycle. With hold,
  // the core keeps cpu_req high carrying nxt so it is accepted in that cycle.
  task automatic complete(input txn_t t, input bit hold, input txn_t nxt);
    int n_acc;
    @(posedge PCLK); @(negedge PCLK);
    check_apb("setup", t, 1'b0);
    if (hold) begin
      cpu_req   = 1'b1;
      cpu_we    = nxt.we;
      cpu_addr  = nxt.addr;
      cpu_wdata = nxt.wdata;
    end else begin
      // Junk request outside IDLE must not disturb the latched transfer.
      cpu_req   = 1'($urandom);
      cpu_we    = 1'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
    end
    n_acc = exp_access(t);
    for (int k = 0; k < n_acc; k++) begin
      @(posedge PCLK); @(negedge PCLK);
      if (!hold) cpu_req = 1'b0;
      check_apb("access", t, 1'b1);
      PREADY  = (k == int'(t.waits));
      PRDATA  = PREADY ? t.prdata : $urandom;
      PSLVERR = PREADY ? t.slverr : 1'($urandom);
    end
    @(posedge PCLK); @(negedge PCLK);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    check("resp.rvalid",  32'(cpu_rvalid), 32'h1);
    check("resp.rdata",   cpu_rdata,       exp_rdata(t));
    check("resp.err",     32'(cpu_err),    32'(exp_err(t)));
    check("resp.ready",   32'(cpu_ready),  32'h1);
    check("resp.psel",    32'(PSEL),       32'h0);
    check("resp.penable", 32'(PENABLE),    32'h0);
    check("resp.paddr",   PADDR,           t.addr);
  endtask

  // One idle cycle after a response: the pulse must be gone.
  task automatic gap();
    @(posedge PCLK); @(negedge PCLK);
    check("gap.rvalid", 32'(cpu_rvalid), 32'h0);
    check("gap.ready",  32'(cpu_ready),  32'h1);
    check("gap.psel",   32'(PSEL),       32'h0);
  endtask

  initial begin
    txn_t a, b, none;
    tests = 0;
    fails = 0;
    none  = '0;

    PRESETn   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state.
    repeat (2) @(negedge PCLK);
    check("rst.ready",   32'(cpu_ready),  32'h0);
    check("rst.rvalid",  32'(cpu_rvalid), 32'h0);
    check("rst.psel",    32'(PSEL),       32'h0);
    check("rst.penable", 32'(PENABLE),    32'h0);
    check("rst.paddr",   PADDR,           32'h0);
    check("rst.pwdata",  PWDATA,          32'h0);
    check("rst.rdata",   cpu_rdata,       32'h0);
    PRESETn = 1'b1;
    #1;
    check("rst.release_ready", 32'(cpu_ready), 32'h1);
    @(negedge PCLK);

    // Write, zero wait.
    a = mk(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    issue(a); complete(a, 1'b0, none); gap();

    // Read, three wait states.
    a = mk(1'b0, 32'h0000_11FC, 32'h0, 3, 32'h1234_5678, 1'b0);
    issue(a); complete(a, 1'b0, none); gap();

    // Slave error on read.
    a = mk(1'b0, 32'h0000_0400, 32'h0, 0, 32'hCAFE_F00D, 1'b1);
    issue(a); complete(a, 1'b0, none); gap();

    // Timeout: slave never ready.
    a = mk(1'b0, 32'h0000_0800, 32'h0, 200, 32'h0, 1'b0);
    issue(a); complete(a, 1'b0, none); gap();

    // Ready on the very cycle the counter hits TIMEOUT: normal completion.
    a = mk(1'b0, 32'h0000_0804, 32'h0, int'(TIMEOUT), 32'h0BAD_CAFE, 1'b0);
    issue(a); complete(a, 1'b0, none); gap();

    // Back-to-back with cpu_req held: B accepted in A's response cycle.
    a = mk(1'b1, 32'h0000_0300, 32'h1111_2222, 1, 32'h0, 1'b0);
    b = mk(1'b0, 32'h0000_0304, 32'h0, 0, 32'h3333_4444, 1'b0);
    issue(a); complete(a, 1'b1, b);
    complete(b, 1'b0, none); gap();

    // Randomized transfers, randomly back-to-back or spaced.
    for (int i = 0; i < 40; i++) begin
      a = rand_txn();
      issue(a);
      complete(a, 1'b0, none);
      if ($urandom_range(0, 1) == 0) gap();
    end
    gap();

    // Populate response registers, then reset mid-ACCESS.
    a = mk(1'b0, 32'h0000_0500, 32'h0, 0, 32'hA5A5_5A5A, 1'b1);
    issue(a); complete(a, 1'b0, none); gap();
    a = mk(1'b1, 32'h0000_0600, 32'h7777_8888, 200, 32'h0, 1'b0);
    issue(a);
    @(posedge PCLK); @(negedge PCLK);
    cpu_req = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    check("mid.penable", 32'(PENABLE), 32'h1);
    PRESETn = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    check("mrst.psel",    32'(PSEL),       32'h0);
    check("mrst.penable", 32'(PENABLE),    32'h0);
    check("mrst.pwrite",  32'(PWRITE),     32'h0);
    check("mrst.paddr",   PADDR,           32'h0);
    check("mrst.pwdata",  PWDATA,          32'h0);
    check("mrst.rvalid",  32'(cpu_rvalid), 32'h0);
    check("mrst.rdata",   cpu_rdata,       32'h0);
    check("mrst.err",     32'(cpu_err),    32'h0);
    check("mrst.ready",   32'(cpu_ready),  32'h0);
    PRESETn = 1'b1;
    #1;
    check("mrst.release_ready", 32'(cpu_ready), 32'h1);
    repeat (3) gap();

    // Bridge still functional after the dropped transfer.
    a = mk(1'b0, 32'h0000_0700, 32'h0, 2, 32'h0F0F_F0F0, 1'b0);
    issue(a); complete(a, 1'b0, none); gap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
